imsic_req_arbiter: RTL and testbench

- Multi-hart arbiter that shares one IMSIC register-access port among NrHarts cores.
- Each hart issues indirect IMSIC accesses (priv level, VS-file select, addr, data, write, claim) with a valid/ready handshake.
- Block grants one request at a time in round-robin order, drives the shared port, waits a fixed latency, and returns data/exception to the requesting hart only.
- Sits in the SoC top between the cva6 instances and the IMSIC.

---
 rtl/imsic_req_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_imsic_req_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_req_arbiter.sv
// Round-robin arbiter sharing one IMSIC register-access port among NrHarts harts.
// Optional macro IMSIC_ARB_MPRIO_EN: M-mode requesters win over lower privilege levels.
module imsic_req_arbiter #(
    parameter int unsigned NrHarts    = 2,
    parameter int unsigned VgeinW     = 3,
    parameter int unsigned AddrW      = 32,
    parameter int unsigned DataW      = 32,
    parameter int unsigned RspLatency = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrHarts-1:0]        hart_req_valid_i,
    output logic [NrHarts-1:0]        hart_req_ready_o,
    input  logic [NrHarts*2-1:0]      hart_priv_lvl_i,
    input  logic [NrHarts*VgeinW-1:0] hart_vgein_i,
    input  logic [NrHarts*AddrW-1:0]  hart_addr_i,
    input  logic [NrHarts*DataW-1:0]  hart_data_i,
    input  logic [NrHarts-1:0]        hart_we_i,
    input  logic [NrHarts-1:0]        hart_claim_i,
    output logic [NrHarts-1:0]        hart_rsp_valid_o,
    output logic [DataW-1:0]          hart_rsp_data_o,
    output logic                      hart_rsp_exception_o,
    output logic                      imsic_valid_o,
    output logic [1:0]                imsic_priv_lvl_o,
    output logic [VgeinW-1:0]         imsic_vgein_o,
    output logic [AddrW-1:0]          imsic_addr_o,
    output logic [DataW-1:0]          imsic_data_o,
    output logic                      imsic_we_o,
    output logic                      imsic_claim_o,
    input  logic [DataW-1:0]          imsic_data_i,
    input  logic                      imsic_exception_i
);

    localparam int unsigned IdxW = (NrHarts > 1) ? $clog2(NrHarts) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] CntLoad = 4'(RspLatency - 1);
    localparam logic [1:0] PrivM   = 2'b11;

    logic [1:0]        state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   gnt_q;
    logic [3:0]        cnt_q;
    logic [1:0]        priv_q;
    logic [VgeinW-1:0] vgein_q;
    logic [AddrW-1:0]  addr_q;
    logic [DataW-1:0]  data_q;
    logic              we_q;
    logic              claim_q;

    logic [NrHarts-1:0] req_elig;
    logic               pick_found;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    ptr_nxt;
    logic               accept;
    int unsigned        cand;

    logic [1:0]        sel_priv;
    logic [VgeinW-1:0] sel_vgein;
    logic [AddrW-1:0]  sel_addr;
    logic [DataW-1:0]  sel_data;
    logic              sel_we;
    logic              sel_claim;

`ifdef IMSIC_ARB_MPRIO_EN
    logic [NrHarts-1:0] m_req;

    // Any valid M-mode requester narrows the round-robin candidate set to M requesters.
    always_comb begin
        m_req = '0;
        for (int unsigned h = 0; h < NrHarts; h++) begin
            m_req[h] = hart_req_valid_i[h] && (hart_priv_lvl_i[2*h +: 2] == PrivM);
        end
        req_elig = (|m_req) ? m_req : hart_req_valid_i;
    end
`else
    assign req_elig = hart_req_valid_i;
`endif

    // First eligible hart at or after the pointer, wrapping modulo NrHarts.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NrHarts; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NrHarts) begin
                cand = cand - NrHarts;
            end
            if (!pick_found && req_elig[IdxW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    assign ptr_nxt = (32'(pick_idx) == NrHarts - 1) ? '0 : pick_idx + 1'b1;

    always_comb begin
        sel_priv  = '0;
        sel_vgein = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_we    = 1'b0;
        sel_claim = 1'b0;
        for (int unsigned h = 0; h < NrHarts; h++) begin
            if (IdxW'(h) == pick_idx) begin
                sel_priv  = hart_priv_lvl_i[2*h +: 2];
                sel_vgein = hart_vgein_i[VgeinW*h +: VgeinW];
                sel_addr  = hart_addr_i[AddrW*h +: AddrW];
                sel_data  = hart_data_i[DataW*h +: DataW];
                sel_we    = hart_we_i[h];
                sel_claim = hart_claim_i[h];
            end
        end
    end

    // Ready is gated by reset so the handshake stays quiet while reset is applied.
    assign accept           = (state_q == ST_IDLE) && pick_found && rst_ni;
    assign hart_req_ready_o = accept ? (NrHarts'(1) << pick_idx) : '0;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            // NOTE: latched request fields are reset too, since they drive the shared port directly.
            priv_q  <= '0;
            vgein_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            claim_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q   <= pick_idx;
                        ptr_q   <= ptr_nxt;
                        priv_q  <= sel_priv;
                        vgein_q <= sel_vgein;
                        addr_q  <= sel_addr;
                        data_q  <= sel_data;
                        we_q    <= sel_we;
                        claim_q <= sel_claim;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= CntLoad;
                    state_q <= (RspLatency == 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imsic_valid_o    = (state_q == ST_ISSUE);
    assign imsic_priv_lvl_o = priv_q;
    assign imsic_vgein_o    = vgein_q;
    assign imsic_addr_o     = addr_q;
    assign imsic_data_o     = data_q;
    assign imsic_we_o       = we_q & imsic_valid_o;
    assign imsic_claim_o    = claim_q & imsic_valid_o;

    // Write acks and faulted accesses return zero data so no stale read value leaks out.
    assign hart_rsp_valid_o     = (state_q == ST_RESP) ? (NrHarts'(1) << gnt_q) : '0;
    assign hart_rsp_exception_o = (state_q == ST_RESP) & imsic_exception_i;
    assign hart_rsp_data_o      = ((state_q == ST_RESP) && !we_q && !imsic_exception_i)
                                  ? imsic_data_i : '0;

endmodule

// File: tb/tb_imsic_req_arbiter.sv
// Bench for imsic_req_arbiter: three instances (RspLatency 1, 3, 4) with table-driven
// transactions, a response scoreboard, and hand-written contention and reset sequences.
module tb_imsic_req_arbiter;

    typedef struct {
        int          k;
        logic [1:0]  valid;
        logic [3:0]  priv;
        logic [1:0]  we;
        logic [1:0]  claim;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
        int          grant;
    } vec_t;

    typedef struct {
        int          k;
        int          hart;
        logic [31:0] data;
        logic        exc;
    } sb_t;

`ifdef IMSIC_ARB_MPRIO_EN
    localparam int MprioGrant = 1;
`else
    localparam int MprioGrant = 0;
`endif

    logic        clk;
    logic        rst_n       [3];
    logic [1:0]  req_valid   [3];
    logic [1:0]  rdy         [3];
    logic [3:0]  priv        [3];
    logic [5:0]  vgein       [3];
    logic [63:0] addr        [3];
    logic [63:0] wdata       [3];
    logic [1:0]  we          [3];
    logic [1:0]  claim       [3];
    logic [1:0]  rsp_valid   [3];
    logic [31:0] rsp_data    [3];
    logic        rsp_exc     [3];
    logic        imsic_valid [3];
    logic [1:0]  imsic_priv  [3];
    logic [2:0]  imsic_vgein [3];
    logic [31:0] imsic_addr  [3];
    logic [31:0] imsic_wdata [3];
    logic        imsic_we    [3];
    logic        imsic_claim [3];
    logic [31:0] imsic_rdata [3];
    logic        imsic_exc   [3];

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t sb[$];
    sb_t mon_e;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imsic_req_arbiter #(
            .NrHarts   (2),
            .VgeinW    (3),
            .AddrW     (32),
            .DataW     (32),
            .RspLatency((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk_i               (clk),
            .rst_ni              (rst_n[g]),
            .hart_req_valid_i    (req_valid[g]),
            .hart_req_ready_o    (rdy[g]),
            .hart_priv_lvl_i     (priv[g]),
            .hart_vgein_i        (vgein[g]),
            .hart_addr_i         (addr[g]),
            .hart_data_i         (wdata[g]),
            .hart_we_i           (we[g]),
            .hart_claim_i        (claim[g]),
            .hart_rsp_valid_o    (rsp_valid[g]),
            .hart_rsp_data_o     (rsp_data[g]),
            .hart_rsp_exception_o(rsp_exc[g]),
            .imsic_valid_o       (imsic_valid[g]),
            .imsic_priv_lvl_o    (imsic_priv[g]),
            .imsic_vgein_o       (imsic_vgein[g]),
            .imsic_addr_o        (imsic_addr[g]),
            .imsic_data_o        (imsic_wdata[g]),
            .imsic_we_o          (imsic_we[g]),
            .imsic_claim_o       (imsic_claim[g]),
            .imsic_data_i        (imsic_rdata[g]),
            .imsic_exception_i   (imsic_exc[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [127:0] outs(input int k);
        return {rdy[k], rsp_valid[k], rsp_data[k], rsp_exc[k], imsic_valid[k], imsic_priv[k],
                imsic_vgein[k], imsic_addr[k], imsic_wdata[k], imsic_we[k], imsic_claim[k]};
    endfunction

    // Response scoreboard plus handshake legality on every cycle something is offered.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdy[k] != 2'b00) begin
                check("rdy_legal", {((rdy[k] & ~req_valid[k]) == 2'b00), $onehot(rdy[k])}, 2'b11);
            end
            if (rsp_valid[k] != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {30'd0, rsp_valid[k]}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp", {8'(k), rsp_valid[k], rsp_data[k], rsp_exc[k]},
                          {8'(mon_e.k), 2'b01 << mon_e.hart, mon_e.data, mon_e.exc});
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int          k;
        int          g;
        int          n;
        logic [1:0]  pv;
        logic [31:0] ea;
        k = v.k;
        g = v.grant;
        req_valid[k]   = v.valid;
        priv[k]        = v.priv;
        we[k]          = v.we;
        claim[k]       = v.claim;
        addr[k]        = {v.addr + 32'h100, v.addr};
        wdata[k]       = {v.wdata, v.wdata};
        imsic_rdata[k] = v.rdata;
        imsic_exc[k]   = v.exc;
        n = 0;
        @(negedge clk);
        while (rdy[k] == 2'b00 && n < 8) begin
            step();
            @(negedge clk);
            n++;
        end
        if (rdy[k] == 2'b00) begin
            check("grant_timeout", n, 0);
            step();
            req_valid[k] = 2'b00;
            return;
        end
        check("grant", rdy[k], 2'b01 << g);
        sb.push_back('{k: k, hart: g, data: (v.we[g] || v.exc) ? 32'h0 : v.rdata, exc: v.exc});
        step();
        req_valid[k] = 2'b00;
        @(negedge clk);
        pv = v.priv[2*g +: 2];
        ea = v.addr + 32'h100 * g;
        check("strobe", {imsic_valid[k], imsic_we[k], imsic_claim[k]}, {1'b1, v.we[g], v.claim[g]});
        check("fwd", {imsic_addr[k], imsic_wdata[k], imsic_priv[k], imsic_vgein[k]},
              {ea, v.wdata, pv, 3'(2 + 3 * g)});
        n = 0;
        do begin
            step();
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("strobe_off", {imsic_valid[k], imsic_we[k], imsic_claim[k]}, 3'b000);
            end
        end while (rsp_valid[k] == 2'b00 && n < 20);
        check("latency", n, lat_of(k));
        step();
    endtask

    initial begin
        vec_t vecs[10];
        vec_t v_post;
        int   gcnt;
        int   scnt;
        int   last_s;
        int   cnt;

        vecs[0] = '{k: 0, valid: 2'b01, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h70,
                    wdata: 32'h0, rdata: 32'hDEADBEEF, exc: 1'b0, grant: 0};
        vecs[1] = '{k: 0, valid: 2'b11, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h80,
                    wdata: 32'h0, rdata: 32'h11112222, exc: 1'b0, grant: 1};
        vecs[2] = '{k: 0, valid: 2'b01, priv: 4'b0101, we: 2'b00, claim: 2'b01, addr: 32'h70,
                    wdata: 32'h0, rdata: 32'h00070007, exc: 1'b0, grant: 0};
        vecs[3] = '{k: 0, valid: 2'b01, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h90,
                    wdata: 32'h0, rdata: 32'h00000042, exc: 1'b0, grant: 0};
        vecs[4] = '{k: 0, valid: 2'b11, priv: 4'b1101, we: 2'b00, claim: 2'b00, addr: 32'hA0,
                    wdata: 32'h0, rdata: 32'h5555AAAA, exc: 1'b0, grant: 1};
        vecs[5] = '{k: 0, valid: 2'b11, priv: 4'b1101, we: 2'b00, claim: 2'b00, addr: 32'hB0,
                    wdata: 32'h0, rdata: 32'h76543210, exc: 1'b0, grant: MprioGrant};
        vecs[6] = '{k: 1, valid: 2'b10, priv: 4'b0101, we: 2'b10, claim: 2'b00, addr: 32'h40,
                    wdata: 32'h5, rdata: 32'hFFFFFFFF, exc: 1'b1, grant: 1};
        vecs[7] = '{k: 1, valid: 2'b11, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h44,
                    wdata: 32'h0, rdata: 32'hCAFEF00D, exc: 1'b0, grant: 0};
        vecs[8] = '{k: 1, valid: 2'b11, priv: 4'b0101, we: 2'b11, claim: 2'b00, addr: 32'h48,
                    wdata: 32'h33, rdata: 32'hFFFFFFFF, exc: 1'b0, grant: 1};
        vecs[9] = '{k: 1, valid: 2'b01, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h4C,
                    wdata: 32'h0, rdata: 32'h1234ABCD, exc: 1'b1, grant: 0};

        for (int k = 0; k < 3; k++) begin
            rst_n[k]       = 1'b0;
            req_valid[k]   = 2'b00;
            priv[k]        = 4'b0;
            vgein[k]       = {3'd5, 3'd2};
            addr[k]        = 64'h0;
            wdata[k]       = 64'h0;
            we[k]          = 2'b00;
            claim[k]       = 2'b00;
            imsic_rdata[k] = 32'h0;
            imsic_exc[k]   = 1'b0;
        end
        step();
        step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_outputs", outs(k), 0);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b1;
        end
        step();

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i]);
        end

        // Back-to-back contention from reset: grants alternate, one strobe every 3 cycles.
        rst_n[0] = 1'b0;
        step();
        step();
        rst_n[0]       = 1'b1;
        req_valid[0]   = 2'b11;
        priv[0]        = 4'b0101;
        we[0]          = 2'b00;
        claim[0]       = 2'b00;
        addr[0]        = {32'h204, 32'h104};
        imsic_rdata[0] = 32'h12345678;
        imsic_exc[0]   = 1'b0;
        gcnt   = 0;
        scnt   = 0;
        last_s = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rdy[0] != 2'b00) begin
                if (gcnt < 4) begin
                    check($sformatf("rr_grant%0d", gcnt), rdy[0], 2'b01 << (gcnt % 2));
                end
                sb.push_back('{k: 0, hart: gcnt % 2, data: 32'h12345678, exc: 1'b0});
                gcnt++;
            end
            if (imsic_valid[0]) begin
                if (scnt > 0) begin
                    check("strobe_gap", c - last_s, 3);
                end
                last_s = c;
                scnt++;
            end
            step();
            if (gcnt >= 4) begin
                req_valid[0] = 2'b00;
            end
        end
        check("rr_grants", gcnt, 4);
        check("rr_strobes", scnt, 4);

        // Reset while waiting: access abandoned, pointer back to hart 0.
        req_valid[2]   = 2'b01;
        priv[2]        = 4'b0101;
        we[2]          = 2'b00;
        claim[2]       = 2'b00;
        addr[2]        = {32'h360, 32'h260};
        imsic_rdata[2] = 32'hBAD0BAD0;
        imsic_exc[2]   = 1'b0;
        @(negedge clk);
        check("rst_pre_grant", rdy[2], 2'b01);
        step();
        req_valid[2] = 2'b00;
        @(negedge clk);
        check("rst_strobe", imsic_valid[2], 1'b1);
        step();
        step();
        rst_n[2] = 1'b0;
        step();
        rst_n[2] = 1'b1;
        @(negedge clk);
        check("rst_outputs", outs(2), 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (rsp_valid[2] != 2'b00 || imsic_valid[2]) begin
                cnt++;
            end
        end
        check("rst_no_rsp", cnt, 0);
        step();
        v_post = '{k: 2, valid: 2'b11, priv: 4'b0101, we: 2'b00, claim: 2'b00, addr: 32'h60,
                   wdata: 32'h0, rdata: 32'h600DF00D, exc: 1'b0, grant: 0};
        run_txn(v_post);

        step();
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
